// File: rtl/cpu_fetch_queue.sv
// Instruction fetch unit with a small in-order queue between memory and decode.
// Issues sequential fetches, buffers {pc, instr} pairs, and flushes on redirect.
module cpu_fetch_queue #(
  parameter int              XLEN        = 64,
  parameter int              DEPTH       = 4,
  parameter int              INSTR_BYTES = 4,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  output logic [XLEN-1:0]            instr_address_out,
  output logic                       instr_read_out,
  input  logic [XLEN-1:0]            instr_read_value_in,
  input  logic                       instr_ready_in,
  input  logic                       branch_mispredicted_in,
  input  logic [XLEN-1:0]            branch_pc_in,
  input  logic                       halt_in,
  input  logic                       deq_ready_in,
  output logic                       valid_out,
  output logic [XLEN-1:0]            pc_out,
  output logic [XLEN-1:0]            instr_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [XLEN-1:0]   fetch_pc_r;
  logic [PW-1:0]     head_r;
  logic [PW-1:0]     tail_r;
  logic [CW-1:0]     count_r;
  logic [XLEN-1:0]   pc_mem_r    [DEPTH];
  logic [XLEN-1:0]   instr_mem_r [DEPTH];
  logic              full_s;
  logic              empty_s;
  logic              enq_s;
  logic              deq_s;

  // Fetch request and handshake qualification.
  always_comb begin
    full_s         = (count_r == CW'(DEPTH));
    empty_s        = (count_r == {CW{1'b0}});
    instr_read_out = reset_n & (state_r == RUN) & ~full_s
                     & ~branch_mispredicted_in & ~halt_in;
    enq_s          = instr_read_out & instr_ready_in;
    // A redirect discards the whole queue, so a same-cycle pop is meaningless.
    deq_s          = ~empty_s & deq_ready_in & ~branch_mispredicted_in;
  end

  // RUN/HALTED next-state logic; redirects never move the state.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (halt_in && !enq_s) begin
          state_nxt_s = HALTED;
        end else begin
          state_nxt_s = RUN;
        end
      end
      HALTED: begin
        if (!halt_in) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = HALTED;
        end
      end
      default: state_nxt_s = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Fetch PC, pointers and occupancy; redirect takes priority over everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_r <= RESET_PC;
      head_r     <= {PW{1'b0}};
      tail_r     <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
    end else if (branch_mispredicted_in) begin
      fetch_pc_r <= branch_pc_in;
      head_r     <= {PW{1'b0}};
      tail_r     <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
    end else begin
      if (enq_s) begin
        fetch_pc_r <= fetch_pc_r + XLEN'(INSTR_BYTES);
        tail_r     <= tail_r + PW'(1);
      end
      if (deq_s) begin
        head_r <= head_r + PW'(1);
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage, written at the tail on each accepted fetch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]    <= {XLEN{1'b0}};
        instr_mem_r[i] <= {XLEN{1'b0}};
      end
    end else if (enq_s) begin
      pc_mem_r[tail_r]    <= fetch_pc_r;
      instr_mem_r[tail_r] <= instr_read_value_in;
    end
  end

  assign instr_address_out = fetch_pc_r;
  assign valid_out         = ~empty_s;
  assign pc_out            = pc_mem_r[head_r];
  assign instr_out         = instr_mem_r[head_r];
  assign count_out         = count_r;

endmodule
